sram_word_responder: RTL and testbench
======================================

SRAM_WORD_RESPONDER -- requirements
Module: sram_word_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 The block SHALL have these parameters:
- ADDR_W, default 10, word-address width (memory depth 2^ADDR_W words of 32 bits).
- WAIT_CYCLES, default 1, busy cycles per access (legal range 0..15).
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wb_stb  in  1  request strobe
- wb_addr  in  32  byte address
- wb_we  in  4  byte write enables (0000 = read)
- wb_din  in  32  write data
- wb_dout  out  32  registered read data
- wb_nak  out  1  registered busy; requester holds or does not issue while high
- err  out  1  sticky out-of-range flag
- acc_cnt  out  16  accepted-access counter

Function
REQ-004 Word index SHALL be wb_addr[ADDR_W+1:2]; wb_addr[1:0] SHALL be ignored.
REQ-005 An address SHALL be in range when wb_addr[31:ADDR_W+2] is zero, and out of range otherwise.
REQ-006 The state machine SHALL have states IDLE and BUSY; wb_nak SHALL be 1 exactly when the state is BUSY.
REQ-007 Acceptance SHALL occur at a rising edge where the state is IDLE and wb_stb=1; addr, we and din SHALL be latched at that edge.
REQ-008 With WAIT_CYCLES=0, the access SHALL execute at the accepting edge and the state SHALL stay IDLE, sustaining one access per cycle.
REQ-009 With WAIT_CYCLES=N>0, acceptance SHALL load a down-counter with N and enter BUSY.
- Each BUSY edge decrements the counter.
- At the edge where the counter equals 1, the latched access executes and the state returns to IDLE.
- wb_nak is therefore high for exactly N cycles.
REQ-010 Write (we≠0): for each i with we[i]=1, memory byte i of the word SHALL take din[8i+7:8i]; other bytes SHALL be unchanged; wb_dout SHALL be unchanged.
REQ-011 Read (we=0): wb_dout SHALL take the memory word at the execute edge and hold it until the next executed read.
REQ-012 Read data SHALL be visible the cycle after execution, i.e. 1+WAIT_CYCLES cycles after acceptance.
REQ-013 An out-of-range write SHALL be dropped; an out-of-range read SHALL load wb_dout=0; either SHALL set err, which stays 1 until reset.
REQ-014 acc_cnt SHALL increment by 1 at every execute edge, in or out of range, and wrap from 16'hFFFF to 0.
REQ-015 wb_stb, wb_addr, wb_we and wb_din SHALL be ignored in BUSY; deasserting wb_stb in BUSY SHALL NOT cancel the latched access.
REQ-016 wb_stb held high across consecutive IDLE edges SHALL be accepted as separate back-to-back accesses.
REQ-017 A read and then a write to the same word, issued back to back, SHALL return the pre-write value; a write then a read SHALL return the post-write value (no forwarding hazard).

Reset
REQ-018 While rst=1 at an edge, the block SHALL force state=IDLE, counter=0, wb_nak=0, wb_dout=0, err=0, acc_cnt=0.
REQ-019 Reset SHALL NOT clear memory contents.
REQ-020 Reset in BUSY SHALL abort the pending access: a pending write is not performed and a pending read does not load wb_dout.
REQ-021 wb_stb=1 during reset SHALL NOT be accepted.
REQ-022 wb_stb still high on the first edge after reset release SHALL be accepted.

Verification
REQ-023 WAIT_CYCLES=1: write addr 0x40, we=1111, din=0x12345678, then read 0x40 -> wb_nak high 1 cycle per access; wb_dout=0x12345678 two cycles after read acceptance; acc_cnt=2.
REQ-024 Byte enables: write 0xFFFFFFFF to word 0x10, then write 0x00AB0000 with we=0100, then read -> 0xFFABFFFF.
REQ-025 WAIT_CYCLES=0: 16 back-to-back reads of 0x0..0x3C after filling with index values -> wb_nak never high; wb_dout sequence 0..15, one per cycle, each one cycle after acceptance.
REQ-026 ADDR_W=10: read 0x00001000 -> wb_dout=0, err=1; write to 0x00001000 leaves word 0 unchanged; err stays 1 until rst.
REQ-027 WAIT_CYCLES=3: accept write of 0xDEADBEEF to 0x8, assert rst during BUSY, release, read 0x8 -> old contents returned; outputs all zero during reset.
REQ-028 65536 accesses -> acc_cnt wraps to 0; a simultaneous same-edge stb while BUSY is ignored (acc_cnt advances by 1 only).

Source files
------------

// File: rtl/sram_word_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_word_responder
// Description : Single-port 32-bit word SRAM behind a strobe/nak request
//               interface. Each accepted access is held for WAIT_CYCLES busy
//               cycles, then executed. Byte-enabled writes, registered read
//               data, sticky out-of-range flag and a wrapping access counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_word_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb,
    input  logic [31:0] wb_addr,
    input  logic [3:0]  wb_we,
    input  logic [31:0] wb_din,
    output logic [31:0] wb_dout,
    output logic        wb_nak,
    output logic        err,
    output logic [15:0] acc_cnt
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT     = 4'(WAIT_CYCLES);
    localparam logic       c_HAS_WAIT = (WAIT_CYCLES != 0);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [31:0]       r_mem [c_DEPTH];

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              w_busy_done;

    // Access captured at acceptance; only consulted when WAIT_CYCLES > 0.
    logic [ADDR_W-1:0] r_idx;
    logic              r_oor;
    logic [3:0]        r_we;
    logic [31:0]       r_din;

    logic [ADDR_W-1:0] w_in_idx;
    logic              w_in_oor;
    logic              w_accept;

    // The access that executes this edge: live inputs for zero-wait,
    // latched copy otherwise.
    logic              w_exec;
    logic [ADDR_W-1:0] w_x_idx;
    logic              w_x_oor;
    logic [3:0]        w_x_we;
    logic [31:0]       w_x_din;

    assign w_in_idx = wb_addr[ADDR_W+1:2];
    assign w_in_oor = |wb_addr[31:ADDR_W+2];
    assign w_accept = (r_state == c_IDLE) && wb_stb;

    // Reset aborts anything that would otherwise execute on this edge.
    assign w_exec  = !rst && (c_HAS_WAIT ? w_busy_done : w_accept);
    assign w_x_idx = c_HAS_WAIT ? r_idx : w_in_idx;
    assign w_x_oor = c_HAS_WAIT ? r_oor : w_in_oor;
    assign w_x_we  = c_HAS_WAIT ? r_we  : wb_we;
    assign w_x_din = c_HAS_WAIT ? r_din : wb_din;

    assign wb_nak = (r_state == c_BUSY);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE accepts and loads the counter, BUSY counts down
    // and executes on the cycle the counter reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (wb_stb && c_HAS_WAIT) begin
                    w_state_nxt = c_BUSY;
                    w_cnt_nxt   = c_WAIT;
                end
            end
            c_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_busy_done = 1'b1;
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request at acceptance; inputs are ignored while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_oor <= 1'b0;
            r_we  <= 4'd0;
            r_din <= 32'd0;
        end else if (w_accept) begin
            r_idx <= w_in_idx;
            r_oor <= w_in_oor;
            r_we  <= wb_we;
            r_din <= wb_din;
        end
    end

    // Byte-enabled memory write; contents survive reset, out-of-range dropped.
    always_ff @(posedge clk) begin
        if (w_exec && !w_x_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w_x_we[i]) begin
                    r_mem[w_x_idx][8*i +: 8] <= w_x_din[8*i +: 8];
                end
            end
        end
    end

    // Read data, sticky error flag and access counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dout <= 32'd0;
            err     <= 1'b0;
            acc_cnt <= 16'd0;
        end else if (w_exec) begin
            acc_cnt <= acc_cnt + 16'd1;
            if (w_x_oor) begin
                err <= 1'b1;
            end
            if (w_x_we == 4'd0) begin
                wb_dout <= w_x_oor ? 32'd0 : r_mem[w_x_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_word_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_word_responder
// Description : Directed self-checking bench. Three instances cover
//               WAIT_CYCLES = 0, 1 and 3 (slots 0, 1, 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_word_responder;

    logic        clk;
    logic        rst   [3];
    logic        stb   [3];
    logic [31:0] addr  [3];
    logic [3:0]  we    [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        nak   [3];
    logic        err   [3];
    logic [15:0] acc   [3];

    int n_checks;
    int n_pass;
    int n_fail;

    sram_word_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .wb_stb(stb[0]), .wb_addr(addr[0]),
        .wb_we(we[0]), .wb_din(din[0]), .wb_dout(dout[0]),
        .wb_nak(nak[0]), .err(err[0]), .acc_cnt(acc[0])
    );

    sram_word_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .wb_stb(stb[1]), .wb_addr(addr[1]),
        .wb_we(we[1]), .wb_din(din[1]), .wb_dout(dout[1]),
        .wb_nak(nak[1]), .err(err[1]), .acc_cnt(acc[1])
    );

    sram_word_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst[2]), .wb_stb(stb[2]), .wb_addr(addr[2]),
        .wb_we(we[2]), .wb_din(din[2]), .wb_dout(dout[2]),
        .wb_nak(nak[2]), .err(err[2]), .acc_cnt(acc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on slot d, returning once the slot is idle again.
    task automatic access(input int d, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] di);
        stb[d]  = 1'b1;
        addr[d] = a;
        we[d]   = w;
        din[d]  = di;
        tick();
        stb[d] = 1'b0;
        for (int k = 0; k < 20 && nak[d]; k++) tick();
        chk("access_done", 32'(nak[d]), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; stb[d] = 1'b0; addr[d] = 32'd0; we[d] = 4'd0; din[d] = 32'd0;
        end
        tick();
        tick();
        chk("rst_nak",  32'(nak[1]), 32'd0);
        chk("rst_dout", dout[1],     32'd0);
        chk("rst_err",  32'(err[1]), 32'd0);
        chk("rst_acc",  32'(acc[1]), 32'd0);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // ---- WAIT_CYCLES=1: write then read, one busy cycle each ----
        stb[1] = 1'b1; addr[1] = 32'h40; we[1] = 4'hF; din[1] = 32'h1234_5678;
        tick();
        chk("w1_nak_busy", 32'(nak[1]), 32'd1);
        stb[1] = 1'b0; addr[1] = 32'hFFFF_FFFF; we[1] = 4'h0;
        tick();
        chk("w1_nak_idle", 32'(nak[1]), 32'd0);
        chk("w1_acc",      32'(acc[1]), 32'd1);
        stb[1] = 1'b1; addr[1] = 32'h40; we[1] = 4'h0;
        tick();
        chk("r1_nak_busy",  32'(nak[1]), 32'd1);
        chk("r1_dout_early", dout[1],    32'd0);
        stb[1] = 1'b0; we[1] = 4'hF; din[1] = 32'd0;
        tick();
        chk("r1_nak_idle", 32'(nak[1]), 32'd0);
        chk("r1_dout",     dout[1],     32'h1234_5678);
        chk("r1_acc",      32'(acc[1]), 32'd2);
        chk("r1_err",      32'(err[1]), 32'd0);

        // ---- byte enables ----
        access(1, 32'h40, 4'hF,    32'hFFFF_FFFF);
        access(1, 32'h40, 4'b0100, 32'h00AB_0000);
        access(1, 32'h43, 4'h0,    32'd0);
        chk("be_dout", dout[1], 32'hFFAB_FFFF);

        // ---- out of range ----
        access(1, 32'h0, 4'hF, 32'h0BAD_F00D);
        access(1, 32'h0, 4'h0, 32'd0);
        chk("w0_dout", dout[1],     32'h0BAD_F00D);
        chk("w0_err",  32'(err[1]), 32'd0);
        access(1, 32'h0000_1000, 4'h0, 32'd0);
        chk("oor_rd_dout", dout[1],     32'd0);
        chk("oor_rd_err",  32'(err[1]), 32'd1);
        access(1, 32'h0000_1000, 4'hF, 32'hAAAA_AAAA);
        access(1, 32'h0, 4'h0, 32'd0);
        chk("oor_wr_dropped", dout[1],     32'h0BAD_F00D);
        chk("oor_err_sticky", 32'(err[1]), 32'd1);

        // ---- strobe during reset ignored, accepted right after release ----
        rst[1] = 1'b1; stb[1] = 1'b1; addr[1] = 32'h0; we[1] = 4'h0;
        tick();
        chk("rst2_nak",  32'(nak[1]), 32'd0);
        chk("rst2_dout", dout[1],     32'd0);
        chk("rst2_err",  32'(err[1]), 32'd0);
        chk("rst2_acc",  32'(acc[1]), 32'd0);
        rst[1] = 1'b0;
        tick();
        chk("rel_nak", 32'(nak[1]), 32'd1);
        stb[1] = 1'b0;
        tick();
        chk("rel_dout_mem_kept", dout[1],     32'h0BAD_F00D);
        chk("rel_acc",           32'(acc[1]), 32'd1);

        // ---- WAIT_CYCLES=0: fill then 16 back-to-back reads ----
        for (int i = 0; i < 16; i++) begin
            stb[0] = 1'b1; addr[0] = 32'(i * 4); we[0] = 4'hF; din[0] = 32'(i);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            addr[0] = 32'(i * 4); we[0] = 4'h0;
            tick();
            chk("z_nak",  32'(nak[0]), 32'd0);
            chk("z_dout", dout[0],     32'(i));
        end
        chk("z_acc", 32'(acc[0]), 32'd32);
        // read then write then read, back to back, same word
        addr[0] = 32'h8; we[0] = 4'h0;
        tick();
        chk("hz_rd_pre", dout[0], 32'd2);
        we[0] = 4'hF; din[0] = 32'h55;
        tick();
        chk("hz_wr_hold", dout[0], 32'd2);
        we[0] = 4'h0;
        tick();
        chk("hz_rd_post", dout[0], 32'h55);
        stb[0] = 1'b0;
        chk("hz_acc", 32'(acc[0]), 32'd35);

        // ---- access counter wrap ----
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("wrap_start", 32'(acc[0]), 32'd0);
        stb[0] = 1'b1; addr[0] = 32'h0; we[0] = 4'h0;
        repeat (65535) tick();
        chk("wrap_ffff", 32'(acc[0]), 32'h0000_FFFF);
        tick();
        chk("wrap_zero", 32'(acc[0]), 32'd0);
        stb[0] = 1'b0;

        // ---- WAIT_CYCLES=3: reset aborts a pending write ----
        access(2, 32'h8, 4'hF, 32'h1111_1111);
        stb[2] = 1'b1; addr[2] = 32'h8; we[2] = 4'hF; din[2] = 32'hDEAD_BEEF;
        tick();
        chk("w3_nak_a", 32'(nak[2]), 32'd1);
        stb[2] = 1'b0;
        tick();
        chk("w3_nak_b", 32'(nak[2]), 32'd1);
        rst[2] = 1'b1;
        tick();
        chk("w3_rst_nak",  32'(nak[2]), 32'd0);
        chk("w3_rst_dout", dout[2],     32'd0);
        chk("w3_rst_err",  32'(err[2]), 32'd0);
        chk("w3_rst_acc",  32'(acc[2]), 32'd0);
        rst[2] = 1'b0;
        tick();
        chk("w3_idle", 32'(nak[2]), 32'd0);
        // read with strobe held high throughout
        stb[2] = 1'b1; addr[2] = 32'h8; we[2] = 4'h0;
        tick();
        chk("r3_e1_nak", 32'(nak[2]), 32'd1);
        chk("r3_e1_acc", 32'(acc[2]), 32'd0);
        tick();
        chk("r3_e2_nak", 32'(nak[2]), 32'd1);
        tick();
        chk("r3_e3_nak",  32'(nak[2]), 32'd1);
        chk("r3_e3_dout", dout[2],     32'd0);
        chk("r3_e3_acc",  32'(acc[2]), 32'd0);
        tick();
        chk("r3_e4_nak",  32'(nak[2]), 32'd0);
        chk("r3_e4_dout", dout[2],     32'h1111_1111);
        chk("r3_e4_acc",  32'(acc[2]), 32'd1);
        tick();
        chk("r3_e5_nak", 32'(nak[2]), 32'd1);
        chk("r3_e5_acc", 32'(acc[2]), 32'd1);
        stb[2] = 1'b0;
        for (int k = 0; k < 20 && nak[2]; k++) tick();
        chk("r3_final_acc", 32'(acc[2]), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
